tx_serial_cfg: RTL and testbench
================================

Name: tx_serial_cfg

Overview:
Parametrised asynchronous serial transmitter, the successor to the fixed 7-bit/parity/1-stop transmitter. Data width and baud divisor are set at build time. Parity mode and stop-bit count are selected at run time and latched per frame. A small internal FIFO accepts words through a write strobe, so the sonar controller can queue measurement strings without waiting for each frame to finish.

Parameters:
DATA_BITS, 7, data bits per frame (legal 5..9)
DIV, 434, clocks per bit (50 MHz / 115200); legal >= 2
FIFO_DEPTH, 4, queued words (power of two, >= 2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high; clears everything
escreve  in  1  write strobe; one word per cycle high
dados  in  DATA_BITS  word written when escreve=1
paridade_modo  in  2  00 none, 01 even, 10 odd, 11 none
dois_stop  in  1  0 = 1 stop bit, 1 = 2 stop bits
saida_serial  out  1  TX line, idle high
cheio  out  1  FIFO full (registered)
vazio  out  1  FIFO empty (registered)
ocupado  out  1  FSM not in IDLE
pronto  out  1  one-cycle pulse at end of each frame
erro_overflow  out  1  sticky; set by a write while cheio; cleared only by reset
db_estado  out  4  current state code

Behaviour:
- Reset values (cycle after reset high): saida_serial=1, cheio=0, vazio=1, ocupado=0, pronto=0, erro_overflow=0, db_estado=0. FIFO pointers are cleared.
- FIFO write:
  - escreve=1 and cheio=0: the word is stored.
  - escreve=1 and cheio=1: the word is dropped and erro_overflow is set. This applies even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full or empty: both take effect and the count is unchanged.
- State codes: IDLE=0, START=1, DADOS=2, PARIDADE=3, STOP=4, FIM=5.
- IDLE: saida_serial=1. If vazio=0, pop the FIFO head into the shift register and latch paridade_modo and dois_stop into frame registers. Next state is START.
  - Config changes mid-frame have no effect.
  - A word written while in IDLE with an empty FIFO is popped on the following cycle at the earliest.
- Bit-time counter: 0..DIV-1. It is zeroed on entry to every state except IDLE and FIM. The bit ends when count = DIV-1.
- START: line=0 for DIV cycles, then DADOS.
- DADOS:
  - line = shift register bit 0, LSB first.
  - Each bit lasts DIV cycles; the register shifts right and the bit index increments at bit end.
  - After DATA_BITS bits, go to PARIDADE if the latched mode is 01 or 10, else go to STOP.
- PARIDADE: line = XOR of the data bits for even parity, or its inverse for odd parity, for DIV cycles. Parity is computed from the word at pop time. Then STOP.
- STOP: line=1 for DIV cycles, or 2*DIV if dois_stop was latched. Then FIM.
- FIM: one cycle, line=1, pronto=1, next state IDLE.
- ocupado=1 in every state except IDLE.
- Frame length from the first start-bit cycle to the last stop cycle is DIV*(1+DATA_BITS+P+S) cycles, where P is 0/1 and S is 1/2.
- Back-to-back frames are separated by exactly 2 extra high cycles (FIM and IDLE).
- Reset mid-frame: the line returns high the next cycle, queued words are discarded and no pronto is issued.
- Codes 6..15 are illegal; they recover to IDLE with the line high.

Decomposition:
- Shared package: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and state code constants (used by db_estado and hexa7seg debug).
- One natural sub-module: tx_fifo_sync.
  - Parameters: WIDTH, DEPTH.
  - Behaviour: synchronous reset, registered cheio/vazio, push/pop ports.
- The bit-time counter is inline, or uses the existing contador_m with M=DIV and zera_s driven by the FSM.

Test Plan (bench uses DIV=4, DATA_BITS=7, FIFO_DEPTH=4):
- Write 0x41 with mode 01 and dois_stop=0 → line reads 0,1,0,0,0,0,0,1,0 (even parity),1. Each bit is 4 cycles, 40 cycles total. pronto pulses once; ocupado is high throughout.
- Write 0x41 with mode 10 and dois_stop=1 → parity bit=1, stop held 8 cycles, frame length 44 cycles.
- Write 0x55 with mode 00 → no parity bit, frame 36 cycles, line 0,1,0,1,0,1,0,1,1.
- Write 5 words in 5 consecutive cycles while IDLE → the first is popped, 4 are queued (cheio=1 after the 5th), and erro_overflow stays 0. A 6th write sets erro_overflow=1 and that word never appears on the line. The frames that follow are each separated by exactly 2 high cycles.
- Change paridade_modo from 01 to 10 during DADOS → the current frame still uses even parity; the next frame uses odd.
- Assert reset during DADOS → saida_serial=1, vazio=1, ocupado=0 and db_estado=0 the next cycle; no pronto pulse; later writes transmit normally.

Source files
------------

// File: rtl/tx_serial_cfg_pkg.sv
// Shared constants for the configurable serial transmitter and its debug display.
package tx_serial_cfg_pkg;

    // Parity mode encoding on paridade_modo (11 also means no parity)
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // FSM state codes, also shown on db_estado / hexa7seg
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_START    = 4'd1;
    localparam logic [3:0] ST_DADOS    = 4'd2;
    localparam logic [3:0] ST_PARIDADE = 4'd3;
    localparam logic [3:0] ST_STOP     = 4'd4;
    localparam logic [3:0] ST_FIM      = 4'd5;

    // Width of the data-bit / stop-bit index (DATA_BITS is at most 9)
    localparam int unsigned IDX_W = 4;

    // True when the mode inserts a parity bit
    function automatic logic has_parity(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

    // Line value of the parity bit given the XOR of the data bits
    function automatic logic parity_bit(input logic [1:0] mode, input logic xor_bits);
        return (mode == PAR_ODD) ? ~xor_bits : xor_bits;
    endfunction

endpackage

// File: rtl/tx_serial_cfg_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
module tx_fifo_sync #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             cheio,
    output logic             vazio
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cheio_q, cheio_d, vazio_q, vazio_d;
    logic             push_ok, pop_ok;

    // Pointer/count update; a push while full is dropped even if a pop happens
    always_comb begin
        push_ok = push & ~cheio_q;
        pop_ok  = pop & ~vazio_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_ok) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_d = rd_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        cheio_d = (cnt_d == CNT_W'(DEPTH));
        vazio_d = (cnt_d == '0);
    end

    // Control registers
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            cheio_q <= 1'b0;
            vazio_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            cheio_q <= cheio_d;
            vazio_q <= vazio_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign cheio    = cheio_q;
    assign vazio    = vazio_q;

endmodule

// File: rtl/tx_serial_cfg.sv
// Configurable async serial transmitter fed by a small word FIFO.
module tx_serial_cfg
    import tx_serial_cfg_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 7,
    parameter int unsigned DIV        = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 escreve,
    input  logic [DATA_BITS-1:0] dados,
    input  logic [1:0]           paridade_modo,
    input  logic                 dois_stop,
    output logic                 saida_serial,
    output logic                 cheio,
    output logic                 vazio,
    output logic                 ocupado,
    output logic                 pronto,
    output logic                 erro_overflow,
    output logic [3:0]           db_estado
);

    localparam int unsigned CNT_W = $clog2(DIV);

    logic [DATA_BITS-1:0] head;
    logic                 pop;

    logic [3:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [1:0]           mode_q, mode_d;
    logic                 two_q, two_d;
    logic                 xor_q, xor_d;
    logic                 line_q, line_d;
    logic                 pronto_q, pronto_d;
    logic                 ocupado_q, ocupado_d;
    logic                 erro_q, erro_d;
    logic                 bit_end;

    tx_fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (escreve),
        .push_data (dados),
        .pop       (pop),
        .pop_data  (head),
        .cheio     (cheio),
        .vazio     (vazio)
    );

    // Next state, bit timing and the registered line value for the next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        mode_d  = mode_q;
        two_d   = two_q;
        xor_d   = xor_q;
        pop     = 1'b0;
        bit_end = (cnt_q == CNT_W'(DIV - 1));
        erro_d  = erro_q | (escreve & cheio);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!vazio) begin
                    pop     = 1'b1;
                    shift_d = head;
                    mode_d  = paridade_modo;
                    two_d   = dois_stop;
                    xor_d   = ^head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_DADOS;
                end
            end
            ST_DADOS: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = has_parity(mode_q) ? ST_PARIDADE : ST_STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_PARIDADE: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (two_q && (idx_q == '0)) begin
                        idx_d = IDX_W'(1);
                    end else begin
                        state_d = ST_FIM;
                    end
                end
            end
            ST_FIM: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        case (state_d)
            ST_START:    line_d = 1'b0;
            ST_DADOS:    line_d = shift_d[0];
            ST_PARIDADE: line_d = parity_bit(mode_d, xor_d);
            default:     line_d = 1'b1;
        endcase
        pronto_d  = (state_d == ST_FIM);
        ocupado_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            mode_q    <= PAR_NONE;
            two_q     <= 1'b0;
            xor_q     <= 1'b0;
            line_q    <= 1'b1;
            pronto_q  <= 1'b0;
            ocupado_q <= 1'b0;
            erro_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            mode_q    <= mode_d;
            two_q     <= two_d;
            xor_q     <= xor_d;
            line_q    <= line_d;
            pronto_q  <= pronto_d;
            ocupado_q <= ocupado_d;
            erro_q    <= erro_d;
        end
    end

    assign saida_serial  = line_q;
    assign pronto        = pronto_q;
    assign ocupado       = ocupado_q;
    assign erro_overflow = erro_q;
    assign db_estado     = state_q;

endmodule

// File: tb/tb_tx_serial_cfg.sv
// Bench for tx_serial_cfg: table vectors plus queued, mid-frame and reset sequences.
module tb_tx_serial_cfg;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       escreve = 1'b0;
    logic [6:0] dados = '0;
    logic [1:0] paridade_modo = 2'b00;
    logic       dois_stop = 1'b0;
    logic       saida_serial, cheio, vazio, ocupado, pronto, erro_overflow;
    logic [3:0] db_estado;

    int n_tests = 0;
    int n_fail  = 0;

    tx_serial_cfg #(.DATA_BITS(7), .DIV(4), .FIFO_DEPTH(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .escreve       (escreve),
        .dados         (dados),
        .paridade_modo (paridade_modo),
        .dois_stop     (dois_stop),
        .saida_serial  (saida_serial),
        .cheio         (cheio),
        .vazio         (vazio),
        .ocupado       (ocupado),
        .pronto        (pronto),
        .erro_overflow (erro_overflow),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        bit          chk_gap;
    } frame_t;

    typedef struct {
        logic [6:0]  data;
        logic [1:0]  mode;
        logic        two;
        logic [15:0] bits;
        int          nbits;
    } vec_t;

    frame_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference frame builder: start, LSB-first data, optional parity, stop bit(s)
    function automatic frame_t model(input logic [6:0] d, input logic [1:0] m,
                                     input bit two, input bit g);
        frame_t f;
        int n;
        f.bits = '0;
        n = 1;
        for (int i = 0; i < 7; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (m == 2'b01 || m == 2'b10) begin
            f.bits[n] = (m == 2'b10) ? ~(^d) : ^d;
            n++;
        end
        f.bits[n] = 1'b1;
        n++;
        if (two) begin
            f.bits[n] = 1'b1;
            n++;
        end
        f.nbits = n;
        f.chk_gap = g;
        return f;
    endfunction

    // Line monitor: matches each frame cycle-by-cycle against the scoreboard head
    frame_t      cur;
    bit          in_frame = 0, fim_next = 0, bogus = 0, ok = 0;
    int          k = 0, gap = 0;
    logic [15:0] cap;

    always @(negedge clock) begin
        if (reset) begin
            in_frame = 0;
            fim_next = 0;
            gap = 0;
        end else if (fim_next) begin
            fim_next = 0;
            check("fim_cycle", {29'b0, saida_serial, pronto, ocupado}, 32'h7);
            gap = 1;
        end else begin
            if (!in_frame) begin
                if (pronto !== 1'b0) check("spurious_pronto", {31'b0, pronto}, 32'h0);
                if (saida_serial === 1'b0) begin
                    in_frame = 1;
                    k = 0;
                    ok = 1;
                    cap = '0;
                    if (sb.size() == 0) begin
                        bogus = 1;
                        cur.nbits = 9;
                        cur.bits = '0;
                        check("unexpected_frame", 32'h1, 32'h0);
                    end else begin
                        bogus = 0;
                        cur = sb.pop_front();
                        if (cur.chk_gap) check("frame_gap", gap, 2);
                    end
                end else begin
                    gap++;
                end
            end
            if (in_frame) begin
                if (saida_serial !== cur.bits[k/4] || ocupado !== 1'b1 || pronto !== 1'b0)
                    ok = 0;
                if (k % 4 == 2) cap[k/4] = saida_serial;
                k++;
                if (k == cur.nbits * 4) begin
                    in_frame = 0;
                    if (!bogus) begin
                        fim_next = 1;
                        check("frame", {15'b0, ok, cap}, {15'b0, 1'b1, cur.bits});
                    end
                end
            end
        end
    end

    task automatic write_word(input logic [6:0] d);
        @(posedge clock);
        #1;
        escreve = 1'b1;
        dados = d;
        @(posedge clock);
        #1;
        escreve = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while ((sb.size() != 0 || in_frame || fim_next) && c < budget) begin
            @(negedge clock);
            c++;
        end
        if (c >= budget) check("wait_done_timeout", 32'h1, 32'h0);
        repeat (3) @(negedge clock);
    endtask

    task automatic wait_state(input logic [3:0] code, input int budget);
        int c = 0;
        while (db_estado !== code && c < budget) begin
            @(negedge clock);
            c++;
        end
        if (c >= budget) check("wait_state_timeout", 32'h1, 32'h0);
    endtask

    vec_t vecs[6];
    logic [6:0] burst[6];

    initial begin
        vecs[0] = '{7'h41, 2'b01, 1'b0, 16'h0282, 10};
        vecs[1] = '{7'h41, 2'b10, 1'b1, 16'h0782, 11};
        vecs[2] = '{7'h55, 2'b00, 1'b0, 16'h01AA, 9};
        vecs[3] = '{7'h7F, 2'b10, 1'b0, 16'h02FE, 10};
        vecs[4] = '{7'h00, 2'b11, 1'b1, 16'h0300, 10};
        vecs[5] = '{7'h2C, 2'b01, 1'b1, 16'h0758, 11};
        burst[0] = 7'h11; burst[1] = 7'h22; burst[2] = 7'h33;
        burst[3] = 7'h44; burst[4] = 7'h55; burst[5] = 7'h7E;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("reset_state", {22'b0, saida_serial, cheio, vazio, ocupado, pronto,
                              erro_overflow, db_estado}, {22'b0, 6'b101000, 4'h0});

        // Single frames from the vector table
        for (int i = 0; i < 6; i++) begin
            paridade_modo = vecs[i].mode;
            dois_stop = vecs[i].two;
            sb.push_back('{vecs[i].bits, vecs[i].nbits, 1'b0});
            write_word(vecs[i].data);
            wait_done(200);
        end

        // Five back-to-back writes fill the FIFO; a sixth overflows
        paridade_modo = 2'b01;
        dois_stop = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            escreve = 1'b1;
            dados = burst[i];
            sb.push_back(model(burst[i], 2'b01, 1'b0, i > 0));
        end
        @(posedge clock);
        #1;
        escreve = 1'b0;
        @(negedge clock);
        check("cheio_after5", {31'b0, cheio}, 32'h1);
        check("no_overflow_yet", {31'b0, erro_overflow}, 32'h0);
        write_word(burst[5]);
        @(negedge clock);
        check("overflow_set", {30'b0, erro_overflow, cheio}, 32'h3);
        wait_done(800);
        check("overflow_sticky", {30'b0, erro_overflow, vazio}, 32'h3);

        // Mode change during DADOS only affects the next frame
        paridade_modo = 2'b01;
        sb.push_back(model(7'h41, 2'b01, 1'b0, 1'b0));
        write_word(7'h41);
        sb.push_back(model(7'h2C, 2'b10, 1'b0, 1'b1));
        write_word(7'h2C);
        wait_state(4'd2, 100);
        paridade_modo = 2'b10;
        wait_done(300);

        // Reset during DADOS aborts the frame and flushes the queue
        paridade_modo = 2'b00;
        sb.push_back(model(7'h55, 2'b00, 1'b0, 1'b0));
        write_word(7'h55);
        write_word(7'h33);
        wait_state(4'd2, 100);
        @(posedge clock);
        #1;
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        @(negedge clock);
        check("reset_midframe", {24'b0, saida_serial, vazio, ocupado, pronto, db_estado},
              {24'b0, 4'b1100, 4'h0});
        check("reset_clears_err", {31'b0, erro_overflow}, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (80) @(negedge clock);
        check("idle_after_reset", {30'b0, saida_serial, ocupado}, 32'h2);

        paridade_modo = 2'b01;
        dois_stop = 1'b1;
        sb.push_back(model(7'h2C, 2'b01, 1'b1, 1'b0));
        write_word(7'h2C);
        wait_done(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
